// File: rtl/covox_pwm_dac.sv
// Covox-style 8-bit DAC on port #FB, mixed with beeper/tape-out and sent out as a 1-bit stream.
// Default build is PWM; define COVOX_SIGMA_DELTA_EN for a first-order sigma-delta modulator.
module covox_pwm_dac #(
    parameter logic [7:0] BEEP_LEVEL = 8'd64,
    parameter logic [7:0] TAPE_LEVEL = 8'd16
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       covox_wr,
    input  logic [7:0] d,
    input  logic       beeper,
    input  logic       tapeout,
    input  logic       enable,
    output logic [7:0] sample,
    output logic       dac_out
);

    logic       wr_q;
    logic       wr_edge;
    logic [7:0] sample_q, sample_d;
    logic [9:0] mix_sum;
    logic [7:0] mix_q, mix_d;
    logic       dac_q, dac_d;

    // Only the rising edge of the strobe loads, so a long strobe is one write.
    assign wr_edge = covox_wr & ~wr_q;

    always_comb begin
        sample_d = sample_q;
        if (wr_edge) begin
            sample_d = d;
        end
    end

    always_comb begin
        mix_sum = {2'b00, sample_q};
        if (beeper) begin
            mix_sum = mix_sum + {2'b00, BEEP_LEVEL};
        end
        if (tapeout) begin
            mix_sum = mix_sum + {2'b00, TAPE_LEVEL};
        end
        mix_d = (mix_sum > 10'd255) ? 8'hFF : mix_sum[7:0];
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            wr_q     <= 1'b0;
            sample_q <= 8'h00;
            mix_q    <= 8'h00;
        end else begin
            wr_q     <= covox_wr;
            sample_q <= sample_d;
            mix_q    <= mix_d;
        end
    end

`ifdef COVOX_SIGMA_DELTA_EN

    logic [8:0] acc_q, acc_d;

    // The carry out of the 8-bit accumulator is the 1-bit density-modulated output.
    always_comb begin
        acc_d = {1'b0, acc_q[7:0]} + {1'b0, mix_q};
        dac_d = enable & acc_q[8];
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            acc_q <= 9'h000;
            dac_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end

`else

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] level_q, level_d;

    // Level only changes at the wrap so every period carries one whole pulse.
    always_comb begin
        cnt_d   = cnt_q + 8'd1;
        level_d = (cnt_q == 8'hFF) ? mix_q : level_q;
        dac_d   = enable & (cnt_q < level_q);
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 8'h00;
            level_q <= 8'h00;
            dac_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            dac_q   <= dac_d;
        end
    end

`endif

    assign sample  = sample_q;
    assign dac_out = dac_q;

endmodule

// File: tb/tb_covox_pwm_dac.sv
// Self-checking bench for covox_pwm_dac: directed scenarios plus random writes against a
// period-level model (high cycles per 256-cycle window = saturated mix).
`timescale 1ns/1ps
module tb_covox_pwm_dac;

    localparam int BEEP = 64;
    localparam int TAPE = 16;

    logic       cpu_clock = 1'b0;
    logic       reset     = 1'b0;
    logic       covox_wr  = 1'b0;
    logic [7:0] d         = 8'h00;
    logic       beeper    = 1'b0;
    logic       tapeout   = 1'b0;
    logic       enable    = 1'b0;
    logic [7:0] sample;
    logic       dac_out;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;  // edges since reset release; PWM phase is edge_n mod 256
    int nz;
    logic [7:0] rv;
    bit rb, rt;

    covox_pwm_dac #(
        .BEEP_LEVEL(8'd64),
        .TAPE_LEVEL(8'd16)
    ) dut (
        .cpu_clock(cpu_clock),
        .reset    (reset),
        .covox_wr (covox_wr),
        .d        (d),
        .beeper   (beeper),
        .tapeout  (tapeout),
        .enable   (enable),
        .sample   (sample),
        .dac_out  (dac_out)
    );

    always #5 cpu_clock = ~cpu_clock;

    task automatic step();
        @(posedge cpu_clock);
        #1;
        edge_n++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_level(input int s, input bit b, input bit t);
        int m;
        m = s + (b ? BEEP : 0) + (t ? TAPE : 0);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic write_byte(input logic [7:0] v);
        d        = v;
        covox_wr = 1'b1;
        step();
        covox_wr = 1'b0;
    endtask

    // Counts high cycles over 256 edges; in PWM also checks pulses sit at the period start.
    task automatic count_period(input int exp_lvl, input string tag);
        int ones;
        int misplaced;
        ones      = 0;
        misplaced = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (dac_out === 1'b1) ones++;
`ifndef COVOX_SIGMA_DELTA_EN
            if (dac_out !== ((i < exp_lvl) ? 1'b1 : 1'b0)) misplaced++;
`endif
        end
        check({tag, " ones"}, ones, exp_lvl);
`ifndef COVOX_SIGMA_DELTA_EN
        check({tag, " shape"}, misplaced, 0);
`endif
    endtask

    task automatic measure(input int exp_lvl, input string tag);
        step();
        step();
        step();
        for (int i = 0; i < 300 && (edge_n % 256) != 0; i++) step();
        count_period(exp_lvl, tag);
    endtask

    initial begin
        enable   = 1'b1;
        covox_wr = 1'b1;
        d        = 8'h5A;
        repeat (4) step();
        check("reset sample", sample, 8'h00);
        check("reset dac_out", dac_out, 1'b0);

        // Strobe already high when reset releases must still load once.
        d      = 8'h33;
        reset  = 1'b1;
        edge_n = 0;
        step();
        check("release strobe load", sample, 8'h33);
        covox_wr = 1'b0;
        d        = 8'h00;
        step();

        write_byte(8'h80);
        check("wr80 sample", sample, 8'h80);
        measure(model_level(8'h80, 1'b0, 1'b0), "wr80");

        beeper  = 1'b1;
        tapeout = 1'b1;
        write_byte(8'hF0);
        check("wrF0 sample", sample, 8'hF0);
        measure(model_level(8'hF0, 1'b1, 1'b1), "saturate");
        beeper  = 1'b0;
        tapeout = 1'b0;

        d        = 8'h11;
        covox_wr = 1'b1;
        step();
        d = 8'h22;
        repeat (4) step();
        check("held strobe mid", sample, 8'h11);
        repeat (5) step();
        covox_wr = 1'b0;
        check("held strobe single load", sample, 8'h11);
        measure(model_level(8'h11, 1'b0, 1'b0), "held");

`ifndef COVOX_SIGMA_DELTA_EN
        for (int i = 0; i < 300 && (edge_n % 256) != 255; i++) step();
        write_byte(8'h40);
        check("wr at wrap sample", sample, 8'h40);
        count_period(model_level(8'h11, 1'b0, 1'b0), "wrap old level");
        count_period(model_level(8'h40, 1'b0, 1'b0), "wrap new level");
`else
        write_byte(8'h40);
        check("sd wr40 sample", sample, 8'h40);
        measure(64, "sd mix64");
`endif

        write_byte(8'hFF);
        enable = 1'b0;
        nz     = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (dac_out !== 1'b0) nz++;
        end
        check("muted nonzero cycles", nz, 0);
        enable = 1'b1;
        step();
`ifndef COVOX_SIGMA_DELTA_EN
        check("reenable first cycle", dac_out, (((edge_n - 1) % 256) < 255) ? 1 : 0);
`endif
        measure(255, "reenable");

        repeat (100) step();
`ifndef COVOX_SIGMA_DELTA_EN
        check("mid-period high", dac_out, 1'b1);
`endif
        #2;
        reset = 1'b0;
        #1;
        check("async reset dac_out", dac_out, 1'b0);
        check("async reset sample", sample, 8'h00);
`ifdef COVOX_SIGMA_DELTA_EN
        check("async reset acc", dut.acc_q, 9'h000);
`endif
        nz = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge cpu_clock);
            #1;
            if (dac_out !== 1'b0) nz++;
        end
        check("held reset nonzero cycles", nz, 0);
        reset  = 1'b1;
        edge_n = 0;
        step();
        check("post-release dac_out", dac_out, 1'b0);
        measure(0, "post-reset period");

        for (int k = 0; k < 6; k++) begin
            rv      = 8'($urandom_range(0, 255));
            rb      = 1'($urandom_range(0, 1));
            rt      = 1'($urandom_range(0, 1));
            beeper  = rb;
            tapeout = rt;
            write_byte(rv);
            check("rand sample", sample, rv);
            measure(model_level(int'(rv), rb, rt), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
